// File: rtl/spi_register_map_sync.sv
// System-clock register map behind the SPI slave: synchronised write/read strobes, lockable
// config registers, status registers and a sticky access error. Optional macro: STATUS_STICKY_EN.
module spi_register_map_sync #(
  parameter int                    ADDR_WIDTH     = 7,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    NUM_CONFIG_REG = 64,
  parameter int                    NUM_STATUS_REG = 32,
  parameter int                    SYNC_STAGES    = 2,
  parameter int                    LOCK_ADDR      = 0,
  parameter logic [DATA_WIDTH-1:0] CONFIG_RST_VAL = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic [DATA_WIDTH-1:0]                write_data_i,
  input  logic                                 write_en_i,
  input  logic                                 read_en_i,
  output logic [DATA_WIDTH-1:0]                read_data_o,
  output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] config_bus_o,
  output logic [NUM_CONFIG_REG-1:0]            config_wr_stb_o,
  input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_i,
  output logic                                 err_o,
  output logic                                 irq_o
);
  localparam int                    SW       = DATA_WIDTH*NUM_STATUS_REG;
  localparam logic [ADDR_WIDTH-1:0] ERR_ADDR = '1;
`ifdef STATUS_STICKY_EN
  localparam bit STS_WRITABLE = 1'b1;
`else
  localparam bit STS_WRITABLE = 1'b0;
`endif

  if (NUM_CONFIG_REG + NUM_STATUS_REG >= 2**ADDR_WIDTH || SYNC_STAGES < 2 ||
      LOCK_ADDR >= NUM_CONFIG_REG) begin : g_param_chk
    $error("spi_register_map_sync: illegal parameter set");
  end

  // synchronisers; strobes fire on the first synchronised high cycle
  logic [SYNC_STAGES-1:0]         wr_sync, rd_sync;
  logic [SYNC_STAGES-1:0][SW-1:0] sts_sync;
  logic                           wr_s_d, rd_s_d;
  logic                           wr_fire, rd_fire;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_sync  <= '0;
      rd_sync  <= '0;
      sts_sync <= '0;
      wr_s_d   <= 1'b0;
      rd_s_d   <= 1'b0;
    end else begin
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], write_en_i};
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0], read_en_i};
      sts_sync <= {sts_sync[SYNC_STAGES-2:0], status_bus_i};
      wr_s_d   <= wr_sync[SYNC_STAGES-1];
      rd_s_d   <= rd_sync[SYNC_STAGES-1];
    end

  assign wr_fire = wr_sync[SYNC_STAGES-1] & ~wr_s_d;
  assign rd_fire = rd_sync[SYNC_STAGES-1] & ~rd_s_d;

  logic is_cfg, is_sts, lock, cfg_wr_ok;
  logic [NUM_CONFIG_REG-1:0][DATA_WIDTH-1:0] cfg_q;
  logic [NUM_CONFIG_REG-1:0]                 cfg_hit;
  logic [NUM_STATUS_REG-1:0][DATA_WIDTH-1:0] sts_q, sts_d, sts_smp;

  assign is_cfg    = addr_i < ADDR_WIDTH'(NUM_CONFIG_REG);
  assign is_sts    = !is_cfg && (addr_i < ADDR_WIDTH'(NUM_CONFIG_REG + NUM_STATUS_REG));
  assign lock      = cfg_q[LOCK_ADDR][0];
  assign cfg_wr_ok = wr_fire && is_cfg && (addr_i == ADDR_WIDTH'(LOCK_ADDR) || !lock);

  always_comb begin
    cfg_hit = '0;
    for (int n = 0; n < NUM_CONFIG_REG; n++)
      cfg_hit[n] = cfg_wr_ok && (addr_i == ADDR_WIDTH'(n));
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cfg_q           <= {NUM_CONFIG_REG{CONFIG_RST_VAL}};
      config_wr_stb_o <= '0;
    end else begin
      config_wr_stb_o <= cfg_hit;
      for (int n = 0; n < NUM_CONFIG_REG; n++)
        if (cfg_hit[n]) cfg_q[n] <= write_data_i;
    end

  assign config_bus_o = cfg_q;

  // status: live copy, or sticky with W1C where a same-cycle set wins
  assign sts_smp = sts_sync[SYNC_STAGES-1];

  always_comb begin
    sts_d = sts_smp;
`ifdef STATUS_STICKY_EN
    for (int n = 0; n < NUM_STATUS_REG; n++)
      if (wr_fire && addr_i == ADDR_WIDTH'(NUM_CONFIG_REG + n))
        sts_d[n] = sts_smp[n] | (sts_q[n] & ~write_data_i);
      else
        sts_d[n] = sts_smp[n] | sts_q[n];
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sts_q <= '0;
    else       sts_q <= sts_d;

`ifdef STATUS_STICKY_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= |sts_d;
`else
  assign irq_o = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_err, rd_clr, err_set;

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    rd_clr = 1'b0;
    if (is_cfg) begin
      for (int n = 0; n < NUM_CONFIG_REG; n++)
        if (addr_i == ADDR_WIDTH'(n)) rd_val = cfg_q[n];
    end else if (is_sts) begin
      for (int n = 0; n < NUM_STATUS_REG; n++)
        if (addr_i == ADDR_WIDTH'(NUM_CONFIG_REG + n)) rd_val = sts_q[n];
    end else if (addr_i == ERR_ADDR) begin
      rd_val = {{(DATA_WIDTH-1){1'b0}}, err_o};
      rd_clr = 1'b1;
    end else begin
      rd_err = 1'b1;
    end
  end

  // err set beats the read-to-clear of ERR_ADDR in the same cycle
  assign err_set = (wr_fire && !cfg_wr_ok && !(is_sts && STS_WRITABLE)) || (rd_fire && rd_err);

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      err_o       <= 1'b0;
      read_data_o <= '0;
    end else begin
      if (err_set)               err_o <= 1'b1;
      else if (rd_fire && rd_clr) err_o <= 1'b0;
      if (rd_fire) read_data_o <= rd_val;
    end
endmodule

// File: tb/tb_spi_register_map_sync.sv
// Randomised bench for spi_register_map_sync: transaction-level model scheduled by the
// strobe latency rule, compared every cycle, plus literal spot checks.
module tb_spi_register_map_sync;
  localparam int AW = 7, DW = 8, NC = 64, NS = 32, SS = 2, LOCK = 0, ERRA = 127;

  logic               clk = 1'b0, rst = 1'b0;
  logic [AW-1:0]      addr_i = '0;
  logic [DW-1:0]      write_data_i = '0;
  logic               write_en_i = 1'b0, read_en_i = 1'b0;
  logic [DW-1:0]      read_data_o;
  logic [DW*NC-1:0]   config_bus_o;
  logic [NC-1:0]      config_wr_stb_o;
  logic [DW*NS-1:0]   status_bus_i = '0;
  logic               err_o, irq_o;

  spi_register_map_sync dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr_i), .write_data_i(write_data_i),
    .write_en_i(write_en_i), .read_en_i(read_en_i), .read_data_o(read_data_o),
    .config_bus_o(config_bus_o), .config_wr_stb_o(config_wr_stb_o),
    .status_bus_i(status_bus_i), .err_o(err_o), .irq_o(irq_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // model: accesses take effect SS+1 edges after the strobe rises
  typedef struct { int t; bit wr; bit rd; int addr; logic [7:0] data; } ev_t;
  ev_t              evq[$];
  logic [DW*NS-1:0] shist[$];
  logic [7:0]       m_cfg [NC];
  logic [7:0]       m_sts [NS];
  logic [7:0]       m_rd;
  logic             m_err;
  logic [NC-1:0]    m_stb;
  int               cyc = 0;

  always @(posedge clk or posedge rst) begin
    logic [DW*NS-1:0] smp;
    bit set, rclr;
    ev_t ev;
`ifdef STATUS_STICKY_EN
    logic [7:0] clr [NS];
`endif
    if (rst) begin
      foreach (m_cfg[n]) m_cfg[n] = 8'h00;
      foreach (m_sts[n]) m_sts[n] = 8'h00;
      m_rd = 8'h00; m_err = 1'b0; m_stb = '0;
      evq.delete(); shist.delete();
    end else begin
      cyc++;
      m_stb = '0; set = 0; rclr = 0;
`ifdef STATUS_STICKY_EN
      foreach (clr[n]) clr[n] = 8'h00;
`endif
      shist.push_back(status_bus_i);
      smp = '0;
      if (shist.size() > SS) smp = shist.pop_front();
      while (evq.size() > 0 && evq[0].t <= cyc) begin
        ev = evq.pop_front();
        if (ev.rd) begin
          if (ev.addr < NC)             m_rd = m_cfg[ev.addr];
          else if (ev.addr < NC + NS)   m_rd = m_sts[ev.addr - NC];
          else if (ev.addr == ERRA)     begin m_rd = {7'b0, m_err}; rclr = 1; end
          else                          begin m_rd = 8'h00; set = 1; end
        end
        if (ev.wr) begin
          if (ev.addr < NC) begin
            if (ev.addr == LOCK || !m_cfg[LOCK][0]) begin
              m_cfg[ev.addr] = ev.data; m_stb[ev.addr] = 1'b1;
            end else set = 1;
          end else if (ev.addr < NC + NS) begin
`ifdef STATUS_STICKY_EN
            clr[ev.addr - NC] = ev.data;
`else
            set = 1;
`endif
          end else set = 1;
        end
      end
      if (set) m_err = 1'b1;
      else if (rclr) m_err = 1'b0;
      foreach (m_sts[n])
`ifdef STATUS_STICKY_EN
        m_sts[n] = (m_sts[n] & ~clr[n]) | smp[n*8 +: 8];
`else
        m_sts[n] = smp[n*8 +: 8];
`endif
    end
  end

  always @(negedge clk) begin
    logic [DW*NC-1:0] exp_bus;
    logic             exp_irq;
    exp_irq = 1'b0;
    foreach (m_cfg[n]) exp_bus[n*8 +: 8] = m_cfg[n];
`ifdef STATUS_STICKY_EN
    foreach (m_sts[n]) exp_irq = exp_irq | (|m_sts[n]);
`endif
    chk("config_bus", config_bus_o, exp_bus);
    chk("wr_stb", config_wr_stb_o, m_stb);
    chk("read_data", read_data_o, m_rd);
    chk("err", err_o, m_err);
    chk("irq", irq_o, exp_irq);
  end

  task automatic start(input bit w, input bit r, input int a, input logic [7:0] d);
    @(posedge clk); #1;
    addr_i = AW'(a); write_data_i = d; write_en_i = w; read_en_i = r;
    evq.push_back('{t: cyc + SS + 1, wr: w, rd: r, addr: a, data: d});
  endtask

  task automatic finish();
    @(posedge clk); #1;
    write_en_i = 1'b0; read_en_i = 1'b0;
    repeat (SS + 2) @(posedge clk);
  endtask

  task automatic access(input bit w, input bit r, input int a, input logic [7:0] d, input int hold);
    start(w, r, a, d);
    repeat (hold - 1) @(posedge clk);
    finish();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, kind, a, op;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg", config_bus_o, '0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rd", read_data_o, 8'h00);
    chk("rst_stb", config_wr_stb_o, '0);

    // config write: strobe exactly 3 clk after the rise
    start(1, 0, 5, 8'hA5);
    repeat (3) @(negedge clk);
    chk("stb5_early", config_wr_stb_o[5], 1'b0);
    @(negedge clk);
    chk("stb5_pulse", config_wr_stb_o[5], 1'b1);
    chk("cfg5", config_bus_o[47:40], 8'hA5);
    @(negedge clk);
    chk("stb5_once", config_wr_stb_o[5], 1'b0);
    finish();
    access(0, 1, 5, 8'h00, 4);
    chk("rd5", read_data_o, 8'hA5);

    // lock
    access(1, 0, 0, 8'h01, 4);
    access(1, 0, 7, 8'h3C, 4);
    chk("locked_cfg7", config_bus_o[63:56], 8'h00);
    chk("locked_err", err_o, 1'b1);
    access(0, 1, ERRA, 8'h00, 4);
    chk("err_rd", read_data_o, 8'h01);
    chk("err_clr", err_o, 1'b0);
    access(1, 0, 0, 8'h00, 4);
    access(1, 0, 7, 8'h3C, 4);
    chk("unlocked_cfg7", config_bus_o[63:56], 8'h3C);

    // status
    @(posedge clk); #1 status_bus_i[7:0] = 8'h81;
    access(0, 1, 64, 8'h00, 4);
    chk("sts0_rd", read_data_o, 8'h81);
`ifdef STATUS_STICKY_EN
    @(posedge clk); #1 status_bus_i[7:0] = 8'h00;
    access(1, 0, 64, 8'hFF, 4);
    chk("irq_cleared", irq_o, 1'b0);
    @(posedge clk); #1 status_bus_i[26] = 1'b1;
    @(posedge clk); #1 status_bus_i[26] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("irq_set", irq_o, 1'b1);
    access(0, 1, 67, 8'h00, 4);
    chk("sts3_sticky", read_data_o, 8'h04);
    access(1, 0, 67, 8'h04, 4);
    access(0, 1, 67, 8'h00, 4);
    chk("sts3_w1c", read_data_o, 8'h00);
    chk("irq_w1c", irq_o, 1'b0);
    start(1, 0, 67, 8'h04);
    status_bus_i[26] = 1'b1;
    @(posedge clk); #1 status_bus_i[26] = 1'b0;
    repeat (2) @(posedge clk);
    finish();
    access(0, 1, 67, 8'h00, 4);
    chk("sts3_set_wins", read_data_o, 8'h04);
`else
    access(1, 0, 64, 8'hFF, 4);
    chk("sts_wr_err", err_o, 1'b1);
    access(0, 1, ERRA, 8'h00, 4);
`endif

    // level held high fires once
    start(1, 0, 11, 8'h5A);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (config_wr_stb_o[11]) cnt++;
    end
    chk("held_one_stb", cnt, 1);
    finish();

    // same-cycle read and write
    access(1, 0, 9, 8'h11, 4);
    access(1, 1, 9, 8'h22, 4);
    chk("rw_old", read_data_o, 8'h11);
    chk("rw_new", config_bus_o[79:72], 8'h22);

    // reset while the strobe is in the synchroniser
    start(1, 0, 12, 8'h77);
    @(posedge clk); #1 rst = 1'b1; write_en_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_abort_cfg12", config_bus_o[103:96], 8'h00);

    // random traffic
    repeat (250) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        for (int n = 0; n < NS; n++)
          if ($urandom_range(0, 3) == 0) status_bus_i[n*8 +: 8] = 8'($urandom);
      end
      kind = $urandom_range(0, 9);
      if (kind < 5)       a = $urandom_range(0, NC - 1);
      else if (kind == 5) a = LOCK;
      else if (kind < 8)  a = $urandom_range(NC, NC + NS - 1);
      else if (kind == 8) a = ERRA;
      else                a = $urandom_range(NC + NS, ERRA - 1);
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, 8'($urandom), $urandom_range(SS + 1, SS + 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
